// File: rtl/inst_encoder.sv
// Instruction encoder/loader: packs one symbolic instruction per handshake into
// the ID-stage 32-bit word, buffers it, and writes it to consecutive addresses.
module inst_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [3:0]        cond,
  input  logic              s,
  input  logic              imm,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [23:0]       operand,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       count,
  output logic              err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP_WORD = 32'hE1600000;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_MOV = 4'd1,  OP_MVN = 4'd2,  OP_ADD = 4'd3;
  localparam logic [3:0] OP_ADC = 4'd4,  OP_SUB = 4'd5,  OP_SBC = 4'd6,  OP_AND = 4'd7;
  localparam logic [3:0] OP_ORR = 4'd8,  OP_EOR = 4'd9,  OP_CMP = 4'd10, OP_TST = 4'd11;
  localparam logic [3:0] OP_LDR = 4'd12, OP_STR = 4'd13, OP_B   = 4'd14;

  logic [3:0]  opc;
  logic        dp, illegal, s_f;
  logic [3:0]  rn_f, rd_f;
  logic [31:0] enc_word;

  always_comb begin
    opc     = 4'b0000;
    dp      = 1'b1;
    illegal = 1'b0;
    case (op)
      OP_MOV:  opc = 4'b1101;
      OP_MVN:  opc = 4'b1111;
      OP_ADD:  opc = 4'b0100;
      OP_ADC:  opc = 4'b0101;
      OP_SUB:  opc = 4'b0010;
      OP_SBC:  opc = 4'b0110;
      OP_AND:  opc = 4'b0000;
      OP_ORR:  opc = 4'b1100;
      OP_EOR:  opc = 4'b0001;
      OP_CMP:  opc = 4'b1010;
      OP_TST:  opc = 4'b1000;
      OP_NOP, OP_LDR, OP_STR, OP_B: dp = 1'b0;
      default: begin dp = 1'b0; illegal = 1'b1; end
    endcase
  end

  // Compares always set flags and discard Rd; moves have no first operand.
  always_comb begin
    s_f  = (op == OP_CMP || op == OP_TST) ? 1'b1 : s;
    rd_f = (op == OP_CMP || op == OP_TST) ? 4'd0 : rd;
    rn_f = (op == OP_MOV || op == OP_MVN) ? 4'd0 : rn;
    enc_word = NOP_WORD;
    if (dp)
      enc_word = {cond, 2'b00, imm, opc, s_f, rn_f, rd_f, operand[11:0]};
    else if (op == OP_LDR || op == OP_STR)
      enc_word = {cond, 2'b01, 1'b0, 4'b0100, (op == OP_LDR), rn, rd, operand[11:0]};
    else if (op == OP_B)
      enc_word = {cond, 4'b1010, operand};
  end

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full && !start;
  assign wr_valid = !empty && !start;
  assign push     = in_valid && in_ready;
  assign pop      = wr_valid && wr_ready;
  assign wr_data  = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_addr <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else if (start) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_addr <= base_addr;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (illegal) err <= 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        wr_addr <= wr_addr + ADDR_W'(4);
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
    end
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and loader for the ID-stage instruction format: accepts one symbolic instruction per handshake (operation, condition, register fields, operand), packs it into the 32-bit word that the ID-stage control unit decodes, buffers it in a small FIFO, and writes it to consecutive instruction-memory addresses. It sits between a test or boot sequencer and the instruction-memory write port, and lets benches and boot logic build programs without hand-assembled hex.

## Interface
- FIFO_DEPTH, 4: encoded-word buffer depth; power of two, at least 2.
- ADDR_W, 32: byte-address width of the memory write port.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  synchronous pulse: load address, flush FIFO, clear counters and error.
- base_addr  in  ADDR_W  start address, sampled when `start` is high.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept a request.
- op  in  4  operation: 0 NOP, 1 MOV, 2 MVN, 3 ADD, 4 ADC, 5 SUB, 6 SBC, 7 AND, 8 ORR, 9 EOR, 10 CMP, 11 TST, 12 LDR, 13 STR, 14 B, 15 illegal.
- cond  in  4  condition field.
- s  in  1  set-flags request; data-processing operations only.
- imm  in  1  immediate flag; data-processing operations only.
- rn, rd  in  4 each  source and destination registers.
- operand  in  24  [11:0] shift operand or memory offset; [23:0] branch offset.
- wr_valid  out  1  memory write request.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  byte address of the write.
- wr_data  out  32  encoded instruction.
- count  out  16  writes completed since `start` or reset; saturates at 0xFFFF.
- err  out  1  sticky flag: an illegal op was accepted.

## Operation
- Word layout: [31:28] cond, [27:26] mode, [25] I, [24:21] opcode, [20] S, [19:16] Rn, [15:12] Rd, [11:0] operand[11:0].
- Data-processing operations use mode 00, with I=imm and S=s. Opcodes: AND 0000, EOR 0001, SUB 0010, ADD 0100, ADC 0101, SBC 0110, TST 1000, CMP 1010, ORR 1100, MOV 1101, MVN 1111.
  - CMP and TST: S is forced to 1 and Rd to 0.
  - MOV and MVN: Rn is forced to 0.
- LDR and STR use mode 01, I=0 and opcode 0100. S is 1 for LDR and 0 for STR. The `imm` and `s` inputs are ignored.
- B produces {cond, 4'b1010, operand[23:0]}.
- NOP produces the fixed word 32'hE1600000.
- Illegal op 15 is encoded as NOP and sets `err`.
- FIFO: `in_ready` = !full & !start; `wr_valid` = !empty & !start.
  - Push on in_valid & in_ready; pop on wr_valid & wr_ready.
  - Push and pop in the same cycle leaves the occupancy unchanged.
  - There is no bypass: a full FIFO holds `in_ready` low even while a pop is in progress.
  - The head is show-ahead: `wr_data` is always the oldest entry.
- Address counter: `wr_addr` += 4 on each pop, wrapping modulo 2^ADDR_W. `count` increments on each pop.
- `start` has priority over everything. In that cycle no handshake completes; the FIFO is emptied, `wr_addr` <= base_addr, `count` <= 0 and `err` <= 0.
- Reset values: FIFO empty, `wr_addr` = 0, `count` = 0, `err` = 0. This gives `in_ready` = 1 (when `start` is low), `wr_valid` = 0 and `wr_data` = 0.
- Reset in mid-operation discards all buffered words immediately.

## Timing
- Encoding is combinational into the FIFO write port; the word is registered on the accepting edge.
- Latency: request accepted at edge N gives `wr_valid` = 1 from edge N, visible in cycle N+1.
- Throughput: one instruction per cycle when `wr_ready` stays high.
- `wr_valid`, `wr_addr` and `wr_data` stay stable while `wr_valid` is high and `wr_ready` is low.
- `err` rises at the edge that accepts op 15.

## Test plan
- ADD R1,R2,#5 (cond E, imm 1, s 0) after start with base 0x100 -> write of 0xE2821005 at 0x100; `count` = 1.
- Stream LDR R3,[R4,#8], CMP R1,#0 (imm 1), B 0xFFFFFE, MOV R0,#10 (s 1) with `wr_ready` = 1 -> 0xE4943008, 0xE3510000, 0xEAFFFFFE, 0xE3B0000A at consecutive addresses.
- Hold `wr_ready` = 0 and push FIFO_DEPTH+1 requests -> `in_ready` drops after 4 accepts; outputs stay stable. Releasing `wr_ready` drains the FIFO in order.
- Accept op 15 -> 0xE1600000 is written and `err` = 1. A following `start` clears `err`.
- Base 0xFFFFFFFC with two writes -> addresses 0xFFFFFFFC, then 0x00000000.
- Assert `rst_n` low with 3 entries buffered -> `wr_valid` = 0 at once and `count` = 0; no stale words appear after reset.
